// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment display driver.
//
// A refresh FSM (OFF -> DRIVE -> DEAD -> DRIVE ...) walks through the digits.
// Each digit is driven for REFRESH_DIV cycles. DEAD_CYCLES cycles with every
// anode off separate one digit from the next. Digit data lives in shadow
// registers that only change on a load strobe.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   enable         scanning enabled; low turns the display off
//   load           one-cycle strobe capturing digits_in/dp_in/blank_in/lzs
//   digits_in      nibble k = value of digit k (digit 0 least significant)
//   dp_in          per-digit decimal point request (1 = lit)
//   blank_in       per-digit force-dark (segments and decimal point)
//   lzs            leading-zero suppression enable
//   sseg[0:6]      segments a..g, active-low (sseg[0] = a)
//   dp             decimal point, active-low
//   an             digit anodes, polarity set by AN_ACTIVE_LOW
//   digit_idx      index of the digit currently being scanned
//   frame_tick     one-cycle pulse on the first DRIVE cycle after a wrap to digit 0
module seg_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int DEAD_CYCLES   = 16,
  parameter int HEX_MODE      = 1,
  parameter int AN_ACTIVE_LOW = 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzs,
  output logic [0:6]              sseg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_tick
);

  localparam int MAXC = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [PW-1:0] RD_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DC_LAST  = PW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};
  localparam logic [0:6] SEG_DARK = 7'b1111111;
  localparam logic [0:6] SEG_DASH = 7'b1111110;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic                    sh_lzs_q, sh_lzs_d;
  logic [0:6]              sseg_q, sseg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic                    advance_s;
  logic [NUM_DIGITS-1:0]   supp_s;
  logic                    zero_above_s;
  logic [NUM_DIGITS-1:0]   an_on_s;
  logic [3:0]              nib_s;

  // Seven-segment decode, active-low, bit 0 = segment a.
  function automatic logic [0:6] seg_decode(input logic [3:0] v);
    logic [0:6] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = (HEX_MODE != 0) ? 7'b0001000 : SEG_DASH;
      4'hB:    s = (HEX_MODE != 0) ? 7'b1100000 : SEG_DASH;
      4'hC:    s = (HEX_MODE != 0) ? 7'b0110001 : SEG_DASH;
      4'hD:    s = (HEX_MODE != 0) ? 7'b1000010 : SEG_DASH;
      4'hE:    s = (HEX_MODE != 0) ? 7'b0110000 : SEG_DASH;
      4'hF:    s = (HEX_MODE != 0) ? 7'b0111000 : SEG_DASH;
      default: s = SEG_DARK;
    endcase
    return s;
  endfunction

  // Scan FSM next state: prescaler, digit index and frame wrap pulse.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    tick_d    = 1'b0;
    advance_s = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
      presc_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_DRIVE;
          presc_d = '0;
          idx_d   = '0;
        end
        ST_DRIVE: begin
          if (presc_q == RD_LAST) begin
            presc_d = '0;
            if (DEAD_CYCLES == 0) begin
              advance_s = 1'b1;
            end else begin
              state_d = ST_DEAD;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_DEAD: begin
          if (presc_q == DC_LAST) begin
            presc_d   = '0;
            advance_s = 1'b1;
            state_d   = ST_DRIVE;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          presc_d = '0;
          idx_d   = '0;
        end
      endcase
      if (advance_s) begin
        if (idx_q == IDX_LAST) begin
          idx_d  = '0;
          tick_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        tick_d = 1'b0;
      end
    end
  end

  // Shadow registers follow the inputs only on a load strobe.
  always_comb begin
    if (load) begin
      sh_dig_d   = digits_in;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
      sh_lzs_d   = lzs;
    end else begin
      sh_dig_d   = sh_dig_q;
      sh_dp_d    = sh_dp_q;
      sh_blank_d = sh_blank_q;
      sh_lzs_d   = sh_lzs_q;
    end
  end

  // Pin values are built from the next state, index and shadow contents so that
  // anode and segments switch together with the state registers.
  always_comb begin
    zero_above_s = 1'b1;
    supp_s       = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above_s = zero_above_s & (sh_dig_d[4*k +: 4] == 4'd0);
      supp_s[k]    = sh_lzs_d & zero_above_s & (k != 0);
    end
    nib_s   = sh_dig_d[{idx_d, 2'b00} +: 4];
    an_on_s = '0;
    sseg_d  = SEG_DARK;
    dp_d    = 1'b1;
    if (state_d == ST_DRIVE) begin
      an_on_s[idx_d] = 1'b1;
      if (sh_blank_d[idx_d]) begin
        sseg_d = SEG_DARK;
        dp_d   = 1'b1;
      end else begin
        sseg_d = supp_s[idx_d] ? SEG_DARK : seg_decode(nib_s);
        dp_d   = ~sh_dp_d[idx_d];
      end
    end else begin
      an_on_s = '0;
    end
    an_d = (AN_ACTIVE_LOW != 0) ? ~an_on_s : an_on_s;
  end

  // All state, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      presc_q    <= '0;
      idx_q      <= '0;
      sh_dig_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      sh_lzs_q   <= 1'b0;
      sseg_q     <= SEG_DARK;
      dp_q       <= 1'b1;
      an_q       <= AN_OFF;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      sh_dig_q   <= sh_dig_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sh_lzs_q   <= sh_lzs_d;
      sseg_q     <= sseg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      tick_q     <= tick_d;
    end
  end

  assign sseg       = sseg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=2).
// A hex-mode instance and a dash-mode instance share the stimulus. The reference
// model is a frame timeline: t counts cycles since scanning started, and the digit
// and phase follow from t by division by the digit period.
module tb_seg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int DC = 2;
  localparam int P  = RD + DC;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg_h;
    logic [6:0] seg_d;
    logic       dp;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0] dp_in = 4'h0;
  logic [3:0] blank_in = 4'h0;
  logic lzs = 1'b0;

  logic [0:6] sseg_h, sseg_d;
  logic       dp_h, dp_d2, tick_h, tick_d2;
  logic [3:0] an_h, an_d2;
  logic [1:0] idx_h, idx_d2;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int          t_m = -1;
  logic [15:0] sh_dig = 16'h0;
  logic [3:0]  sh_dp = 4'h0, sh_blank = 4'h0;
  logic        sh_lzs = 1'b0;

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
                    .HEX_MODE(1), .AN_ACTIVE_LOW(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in), .lzs(lzs),
    .sseg(sseg_h), .dp(dp_h), .an(an_h), .digit_idx(idx_h), .frame_tick(tick_h));

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
                    .HEX_MODE(0), .AN_ACTIVE_LOW(1)) dut_dash (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in), .lzs(lzs),
    .sseg(sseg_d), .dp(dp_d2), .an(an_d2), .digit_idx(idx_d2), .frame_tick(tick_d2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int k, input bit hexm);
    logic [3:0] v;
    logic [6:0] s;
    v = sh_dig[4*k +: 4];
    s = SEG_TBL[v];
    if (!hexm && v > 4'd9) s = 7'b1111110;
    if (sh_lzs && k > 0 && (sh_dig >> (4*k)) == 16'd0) s = 7'h7F;
    if (sh_blank[k]) s = 7'h7F;
    return s;
  endfunction

  // One cycle of stimulus: apply inputs for the coming edge, advance the model,
  // queue the expected pin values, then move past the edge.
  task automatic step(input logic ld);
    exp_t e;
    int   k;
    load = ld;
    if (ld) begin
      sh_dig = digits_in; sh_dp = dp_in; sh_blank = blank_in; sh_lzs = lzs;
    end
    if (!enable) t_m = -1;
    else t_m = t_m + 1;
    e.an = 4'hF; e.seg_h = 7'h7F; e.seg_d = 7'h7F; e.dp = 1'b1; e.idx = 2'd0; e.tick = 1'b0;
    if (t_m >= 0) begin
      k      = (t_m / P) % N;
      e.idx  = 2'(k);
      e.tick = (t_m > 0) && (t_m % (P * N) == 0);
      if (t_m % P < RD) begin
        e.an    = ~(4'b0001 << k);
        e.seg_h = exp_seg(k, 1'b1);
        e.seg_d = exp_seg(k, 1'b0);
        e.dp    = sh_blank[k] ? 1'b1 : ~sh_dp[k];
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an"}, 32'(an_h), 32'hF);
    chk({tag, "_sseg"}, 32'(sseg_h), 32'h7F);
    chk({tag, "_dp"}, 32'(dp_h), 32'h1);
    chk({tag, "_tick"}, 32'(tick_h), 32'h0);
    chk({tag, "_idx"}, 32'(idx_h), 32'h0);
  endtask

  // Monitor: outputs are presented every cycle; compare one queued entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("an", 32'(an_h), 32'(e.an));
        chk("sseg_hex", 32'(sseg_h), 32'(e.seg_h));
        chk("sseg_dash", 32'(sseg_d), 32'(e.seg_d));
        chk("dp", 32'(dp_h), 32'(e.dp));
        chk("digit_idx", 32'(idx_h), 32'(e.idx));
        chk("frame_tick", 32'(tick_h), 32'(e.tick));
      end
    end
  end

  initial begin
    int guard;
    // Power-on reset
    #1 rst_n = 1'b0;
    #1 check_dark("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Scan timing with 0x1234, loaded together with enable
    enable = 1'b1; digits_in = 16'h1234; dp_in = 4'h0; blank_in = 4'h0; lzs = 1'b0;
    step(1'b1);
    run(2 * P * N);

    // Hex / dash decode
    digits_in = 16'hABCF;
    step(1'b1);
    run(P * N);

    // Leading-zero suppression with a decimal point on a suppressed digit
    digits_in = 16'h0070; lzs = 1'b1; dp_in = 4'b1000;
    step(1'b1);
    run(P * N);

    // Blanking overrides the decimal point; enable drop mid-frame
    digits_in = 16'h5678; lzs = 1'b0; dp_in = 4'b0010; blank_in = 4'b0010;
    step(1'b1);
    run(13);
    enable = 1'b0;
    run(4);
    enable = 1'b1;
    run(P * N);

    // Load during DRIVE of digit 0: 5 -> 8 on its third cycle
    enable = 1'b0; digits_in = 16'h0005; blank_in = 4'h0; dp_in = 4'h0;
    step(1'b1);
    enable = 1'b1;
    run(2);
    digits_in = 16'h0008;
    step(1'b1);
    run(P);

    // Randomized loads and occasional enable drops
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0) begin
        digits_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
        lzs = 1'($urandom);
        if ($urandom_range(0, 1) == 0) digits_in = digits_in & 16'h00FF;
        step(1'b1);
      end else begin
        step(1'b0);
      end
    end

    // Asynchronous reset while digit 2 is being driven
    enable = 1'b1;
    guard = 0;
    while (!(t_m >= 0 && (t_m / P) % N == 2 && t_m % P < RD - 1) && guard < 200) begin
      step(1'b0);
      guard++;
    end
    chk("reach_digit2", 32'(guard < 200), 32'h1);
    chk("pre_reset_an", 32'(an_h), 32'hB);
    rst_n = 1'b0;
    #1 check_dark("midreset");
    chk("midreset_sseg_dash", 32'(sseg_d), 32'h7F);
    t_m = -1; sh_dig = 16'h0; sh_dp = 4'h0; sh_blank = 4'h0; sh_lzs = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run(P * N + 3);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
